// File: rtl/mpsoc_axi4_pkg.sv
// Shared AXI4 definitions: burst encoding, response codes, master FSM states
// and the size-encoding helper used by the AXI4 memory bridge.
package mpsoc_axi4_pkg;

  typedef enum logic [1:0] {
    AXI_BURST_FIXED = 2'b00,
    AXI_BURST_INCR  = 2'b01,
    AXI_BURST_WRAP  = 2'b10
  } axi_burst_t;

  localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
  localparam logic [1:0] AXI_RESP_EXOKAY = 2'b01;
  localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;
  localparam logic [1:0] AXI_RESP_DECERR = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_AR   = 3'd1,
    ST_R    = 3'd2,
    ST_AW_W = 3'd3,
    ST_B    = 3'd4
  } mst_state_t;

  function automatic logic [2:0] axi_size(input int unsigned data_w);
    return 3'($clog2(data_w / 8));
  endfunction

  // Only OKAY and EXOKAY count as success.
  function automatic logic axi_resp_err(input logic [1:0] resp);
    return !((resp == AXI_RESP_OKAY) || (resp == AXI_RESP_EXOKAY));
  endfunction

endpackage

// File: rtl/mpsoc_axi4_mem_master.sv
// Single-outstanding bridge from a req/gnt core memory port to single-beat
// AXI4 INCR transactions, with a registered one-cycle response strobe.
module mpsoc_axi4_mem_master
  import mpsoc_axi4_pkg::*;
#(
  parameter int                      AXI_ID_WIDTH   = 10,
  parameter int                      AXI_ADDR_WIDTH = 64,
  parameter int                      AXI_DATA_WIDTH = 64,
  parameter int                      AXI_STRB_WIDTH = 8,
  parameter int                      AXI_USER_WIDTH = 10,
  parameter logic [AXI_ID_WIDTH-1:0] AXI_ID         = '0
) (
  input  logic                      clk_i,
  input  logic                      rst_i,

  input  logic                      req_i,
  output logic                      gnt_o,
  input  logic                      we_i,
  input  logic [AXI_ADDR_WIDTH-1:0] addr_i,
  input  logic [AXI_STRB_WIDTH-1:0] be_i,
  input  logic [AXI_DATA_WIDTH-1:0] data_i,
  output logic                      rvalid_o,
  output logic [AXI_DATA_WIDTH-1:0] data_o,
  output logic                      err_o,

  output logic [AXI_ID_WIDTH-1:0]   axi_aw_id,
  output logic [AXI_ADDR_WIDTH-1:0] axi_aw_addr,
  output logic [7:0]                axi_aw_len,
  output logic [2:0]                axi_aw_size,
  output logic [1:0]                axi_aw_burst,
  output logic                      axi_aw_lock,
  output logic [3:0]                axi_aw_cache,
  output logic [2:0]                axi_aw_prot,
  output logic [3:0]                axi_aw_qos,
  output logic [3:0]                axi_aw_region,
  output logic [AXI_USER_WIDTH-1:0] axi_aw_user,
  output logic                      axi_aw_valid,
  input  logic                      axi_aw_ready,

  output logic [AXI_DATA_WIDTH-1:0] axi_w_data,
  output logic [AXI_STRB_WIDTH-1:0] axi_w_strb,
  output logic                      axi_w_last,
  output logic [AXI_USER_WIDTH-1:0] axi_w_user,
  output logic                      axi_w_valid,
  input  logic                      axi_w_ready,

  input  logic [AXI_ID_WIDTH-1:0]   axi_b_id,
  input  logic [1:0]                axi_b_resp,
  input  logic [AXI_USER_WIDTH-1:0] axi_b_user,
  input  logic                      axi_b_valid,
  output logic                      axi_b_ready,

  output logic [AXI_ID_WIDTH-1:0]   axi_ar_id,
  output logic [AXI_ADDR_WIDTH-1:0] axi_ar_addr,
  output logic [7:0]                axi_ar_len,
  output logic [2:0]                axi_ar_size,
  output logic [1:0]                axi_ar_burst,
  output logic                      axi_ar_lock,
  output logic [3:0]                axi_ar_cache,
  output logic [2:0]                axi_ar_prot,
  output logic [3:0]                axi_ar_qos,
  output logic [3:0]                axi_ar_region,
  output logic [AXI_USER_WIDTH-1:0] axi_ar_user,
  output logic                      axi_ar_valid,
  input  logic                      axi_ar_ready,

  input  logic [AXI_ID_WIDTH-1:0]   axi_r_id,
  input  logic [AXI_DATA_WIDTH-1:0] axi_r_data,
  input  logic [1:0]                axi_r_resp,
  input  logic                      axi_r_last,
  input  logic [AXI_USER_WIDTH-1:0] axi_r_user,
  input  logic                      axi_r_valid,
  output logic                      axi_r_ready
);

  localparam logic [2:0] AXI_SIZE = axi_size(AXI_DATA_WIDTH);

  mst_state_t                r_state;
  mst_state_t                w_next_state;
  logic [AXI_ADDR_WIDTH-1:0] r_addr;
  logic [AXI_STRB_WIDTH-1:0] r_be;
  logic [AXI_DATA_WIDTH-1:0] r_wdata;
  logic                      r_aw_done;
  logic                      r_w_done;
  logic                      r_rvalid;
  logic [AXI_DATA_WIDTH-1:0] r_rdata;
  logic                      r_err;
  logic                      w_gnt;
  logic                      w_aw_hs;
  logic                      w_w_hs;
  logic                      w_unused;

  // Valids/readies decode only registered state, never the partner handshake input.
  assign axi_ar_valid = (r_state == ST_AR);
  assign axi_r_ready  = (r_state == ST_R);
  assign axi_aw_valid = (r_state == ST_AW_W) && !r_aw_done;
  assign axi_w_valid  = (r_state == ST_AW_W) && !r_w_done;
  assign axi_b_ready  = (r_state == ST_B);

  assign w_aw_hs = axi_aw_valid && axi_aw_ready;
  assign w_w_hs  = axi_w_valid && axi_w_ready;

  always_comb begin
    w_next_state = r_state;
    w_gnt        = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (req_i && !rst_i) begin
          w_gnt        = 1'b1;
          w_next_state = we_i ? ST_AW_W : ST_AR;
        end
      end
      ST_AR:   if (axi_ar_ready) w_next_state = ST_R;
      ST_R:    if (axi_r_valid) w_next_state = ST_IDLE;
      ST_AW_W: if ((r_aw_done || w_aw_hs) && (r_w_done || w_w_hs)) w_next_state = ST_B;
      ST_B:    if (axi_b_valid) w_next_state = ST_IDLE;
      default: w_next_state = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state   <= ST_IDLE;
      r_addr    <= '0;
      r_be      <= '0;
      r_wdata   <= '0;
      r_aw_done <= 1'b0;
      r_w_done  <= 1'b0;
      r_rvalid  <= 1'b0;
      r_rdata   <= '0;
      r_err     <= 1'b0;
    end else begin
      r_state  <= w_next_state;
      r_rvalid <= 1'b0;
      if (w_gnt) begin
        r_addr    <= addr_i;
        r_be      <= be_i;
        r_wdata   <= data_i;
        r_aw_done <= 1'b0;
        r_w_done  <= 1'b0;
      end
      if (w_aw_hs) r_aw_done <= 1'b1;
      if (w_w_hs)  r_w_done  <= 1'b1;
      if ((r_state == ST_R) && axi_r_valid) begin
        r_rdata  <= axi_r_data;
        r_err    <= axi_resp_err(axi_r_resp) || !axi_r_last;
        r_rvalid <= 1'b1;
      end
      if ((r_state == ST_B) && axi_b_valid) begin
        r_err    <= axi_resp_err(axi_b_resp);
        r_rvalid <= 1'b1;
      end
    end
  end

  assign gnt_o    = w_gnt;
  assign rvalid_o = r_rvalid;
  assign data_o   = r_rdata;
  assign err_o    = r_err;

  assign axi_aw_id     = AXI_ID;
  assign axi_aw_addr   = r_addr;
  assign axi_aw_len    = 8'd0;
  assign axi_aw_size   = AXI_SIZE;
  assign axi_aw_burst  = AXI_BURST_INCR;
  assign axi_aw_lock   = 1'b0;
  assign axi_aw_cache  = 4'd0;
  assign axi_aw_prot   = 3'd0;
  assign axi_aw_qos    = 4'd0;
  assign axi_aw_region = 4'd0;
  assign axi_aw_user   = '0;

  assign axi_w_data = r_wdata;
  assign axi_w_strb = r_be;
  assign axi_w_last = 1'b1;
  assign axi_w_user = '0;

  assign axi_ar_id     = AXI_ID;
  assign axi_ar_addr   = r_addr;
  assign axi_ar_len    = 8'd0;
  assign axi_ar_size   = AXI_SIZE;
  assign axi_ar_burst  = AXI_BURST_INCR;
  assign axi_ar_lock   = 1'b0;
  assign axi_ar_cache  = 4'd0;
  assign axi_ar_prot   = 3'd0;
  assign axi_ar_qos    = 4'd0;
  assign axi_ar_region = 4'd0;
  assign axi_ar_user   = '0;

  // IDs and user sidebands on responses are irrelevant with one transaction in flight.
  assign w_unused = ^{axi_r_id, axi_r_user, axi_b_id, axi_b_user};

endmodule
